local_history_predictor: RTL

//  Parametrised two-level local branch predictor: per-PC branch history table (BHT)

---
 rtl/local_history_predictor.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/local_history_predictor.sv
// Two-level local branch predictor: per-PC history table indexing shared saturating counters; LOCAL_PRED_STATS_EN adds lookup/mispredict counters.
// Prediction registered one cycle after the instruction is sampled; no backpressure, and Ready stays low during the table init sweep.
module local_history_predictor #(
  parameter int HIST_BITS    = 10,
  parameter int BHT_IDX_BITS = 10,
  parameter int CTR_BITS     = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr_input,
  input  logic [31:0] Instr_addr_input,
  input  logic        Update_valid,
  input  logic [31:0] Update_addr,
  input  logic        Update_taken,
`ifdef LOCAL_PRED_STATS_EN
  input  logic        Update_predicted,
  output logic [31:0] Stat_lookups,
  output logic [31:0] Stat_mispredicts,
`endif
  output logic        Ready,
  output logic        Pred_valid,
  output logic        Taken
);

  localparam int BHT_DEPTH = 1 << BHT_IDX_BITS;
  localparam int PHT_DEPTH = 1 << HIST_BITS;
  localparam int SWP_BITS  = (BHT_IDX_BITS > HIST_BITS) ? BHT_IDX_BITS : HIST_BITS;
  localparam logic [SWP_BITS-1:0] SWP_LAST    = '1;
  localparam logic [SWP_BITS:0]   BHT_DEPTH_W = (SWP_BITS+1)'(BHT_DEPTH);
  localparam logic [SWP_BITS:0]   PHT_DEPTH_W = (SWP_BITS+1)'(PHT_DEPTH);
  localparam logic [CTR_BITS-1:0] CTR_INIT    = CTR_BITS'((1 << (CTR_BITS-1)) - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state, state_nxt;
  logic [SWP_BITS-1:0] sweep_idx, sweep_nxt;

  logic [HIST_BITS-1:0] bht [BHT_DEPTH];
  logic [CTR_BITS-1:0]  pht [PHT_DEPTH];

  logic [BHT_IDX_BITS-1:0] p_idx, u_idx;
  logic [HIST_BITS-1:0]    p_hist, u_hist, u_hist_nxt;
  logic [CTR_BITS-1:0]     u_ctr, u_ctr_nxt;
  logic                    p_br, p_tk;
  logic                    swp_in_bht, swp_in_pht, upd_en;
  logic                    unused_bits;

  function automatic logic is_branch(input logic [31:0] instr);
    logic [5:0] op;
    logic [4:0] rt;
    op = instr[31:26];
    rt = instr[20:16];
    case (op)
      6'b000100, 6'b000101, 6'b000110, 6'b000111: is_branch = 1'b1;
      6'b000001: is_branch = (rt == 5'b00000) || (rt == 5'b00001) ||
                             (rt == 5'b10000) || (rt == 5'b10001);
      default:   is_branch = 1'b0;
    endcase
  endfunction

  assign p_idx  = Instr_addr_input[BHT_IDX_BITS+1:2];
  assign u_idx  = Update_addr[BHT_IDX_BITS+1:2];
  assign p_hist = bht[p_idx];
  assign p_tk   = pht[p_hist][CTR_BITS-1];
  assign p_br   = is_branch(Instr_input);
  assign u_hist = bht[u_idx];
  assign u_ctr  = pht[u_hist];
  // Shift the outcome in; the cast drops the oldest bit and also covers HIST_BITS=1.
  assign u_hist_nxt = HIST_BITS'({u_hist, Update_taken});

  assign upd_en     = (state == S_RUN) && Update_valid;
  assign swp_in_bht = ({1'b0, sweep_idx} < BHT_DEPTH_W);
  assign swp_in_pht = ({1'b0, sweep_idx} < PHT_DEPTH_W);
  assign Ready      = (state == S_RUN);

  assign unused_bits = ^{Instr_input, Instr_addr_input, Update_addr};

  always_comb begin
    u_ctr_nxt = u_ctr;
    if (Update_taken && (u_ctr != '1))
      u_ctr_nxt = u_ctr + CTR_BITS'(1);
    else if (!Update_taken && (u_ctr != '0))
      u_ctr_nxt = u_ctr - CTR_BITS'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_INIT;
      sweep_idx <= '0;
    end else begin
      state     <= state_nxt;
      sweep_idx <= sweep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep_idx;
    if (state == S_INIT) begin
      sweep_nxt = sweep_idx + SWP_BITS'(1);
      if (sweep_idx == SWP_LAST)
        state_nxt = S_RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if ((state == S_INIT) && swp_in_bht)
        bht[sweep_idx[BHT_IDX_BITS-1:0]] <= '0;
      else if (upd_en)
        bht[u_idx] <= u_hist_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if ((state == S_INIT) && swp_in_pht)
        pht[sweep_idx[HIST_BITS-1:0]] <= CTR_INIT;
      else if (upd_en)
        pht[u_hist] <= u_ctr_nxt;
    end
  end

  // Table reads above happen before this edge's writes, so a same-cycle update never affects the prediction.
  always_ff @(posedge CLK) begin
    if (RESET || (state != S_RUN)) begin
      Pred_valid <= 1'b0;
      Taken      <= 1'b0;
    end else begin
      Pred_valid <= p_br;
      Taken      <= p_br & p_tk;
    end
  end

`ifdef LOCAL_PRED_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Stat_lookups     <= '0;
      Stat_mispredicts <= '0;
    end else if (state == S_RUN) begin
      if (p_br && (Stat_lookups != '1))
        Stat_lookups <= Stat_lookups + 32'd1;
      if (Update_valid && (Update_predicted != Update_taken) && (Stat_mispredicts != '1))
        Stat_mispredicts <= Stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
